multiword_add_ctrl: RTL and testbench

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

---
 rtl/multiword_add_pkg.sv | 14 +
 rtl/multiword_add_ctrl_adder_4bit.sv | 20 ++
 rtl/multiword_add_ctrl.sv | 128 ++++++++++++
 tb/tb_multiword_add_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multiword_add_pkg.sv
// Shared definitions for the nibble-serial multiword adder.
//   NIBBLE_W : width of one serial add step (the shared adder width)
//   state_e  : controller states IDLE / RUN / DONE
package multiword_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : multiword_add_pkg

// File: rtl/multiword_add_ctrl_adder_4bit.sv
// One nibble-wide ripple adder, shared by every step of the serial add.
// Ports:
//   a, b : nibble addends
//   cin  : carry-in from the previous nibble
//   sum  : nibble result
//   cout : carry into the next nibble
module adder_4bit
  import multiword_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // Zero-extend everything to NIBBLE_W+1 bits so the carry lands in the MSB.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule : adder_4bit

// File: rtl/multiword_add_ctrl.sv
// Nibble-serial W-bit adder with valid/ready handshakes on both sides.
// Operands are latched on accept, then one nibble per cycle is added through
// a single shared 4-bit adder (NWORDS cycles), and the result is held in DONE
// until the consumer takes it.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, cin           : W-bit addends and carry-in
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum                 : result (partial while running)
//   cout, ovf           : unsigned carry-out, two's-complement overflow (DONE only)
//   busy                : high while nibbles are being added
module multiword_add_ctrl
  import multiword_add_pkg::*;
#(
  parameter  int NWORDS = 4,
  localparam int W      = NIBBLE_W * NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q,     a_d;
  logic [W-1:0]       b_q,     b_d;
  logic [W-1:0]       sum_q,   sum_d;

  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;

  // The single adder always looks at the nibble selected by idx_q; its result
  // is only consumed in RUN.
  adder_4bit u_adder (
    .a    (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b    (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    cout      = 1'b0;
    ovf       = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        busy = 1'b1;
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = add_sum;
        carry_d = add_cout;
        // idx parks on the last nibble instead of wrapping.
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end

      DONE: begin
        out_valid = 1'b1;
        cout      = carry_q;
        // Same-sign addends producing a result of the other sign.
        ovf       = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign sum = sum_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values from
    // before this edge, regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

endmodule : multiword_add_ctrl

// File: tb/tb_multiword_add_ctrl.sv
// Directed bench for multiword_add_ctrl: a driver issues transactions and
// pushes hand-computed results into a scoreboard queue; a monitor pops and
// compares whenever a result handshake happens.
module tb_multiword_add_ctrl;

  localparam int NWORDS = 4;
  localparam int W      = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  multiword_add_ctrl #(.NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         disturb;  // wiggle in_valid / operands during RUN
    logic         early;    // out_ready already high during RUN
    logic [3:0]   hold;     // DONE cycles with out_ready low
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on any edge where out_valid && out_ready.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got result 0x%0h with no pending expectation", sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_sum",  32'(sum),  32'(e.sum));
        check("sb_cout", 32'(cout), 32'(e.cout));
        check("sb_ovf",  32'(ovf),  32'(e.ovf));
      end
    end
  end

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic run_txn(input vec_t v);
    int   edges;
    int   busy_cnt;
    logic [W-1:0] s_snap;
    logic c_snap, o_snap;
    wait_in_ready();
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    in_valid = 1'b1;
    out_ready = v.early;
    sb.push_back('{sum: v.sum, cout: v.cout, ovf: v.ovf});
    @(posedge clk); #1;              // accept edge counts as edge 1
    in_valid = 1'b0;
    edges    = 1;
    busy_cnt = 0;
    while (!out_valid && edges < 30) begin
      if (busy) busy_cnt++;
      if (v.disturb) begin
        in_valid = ~in_valid;
        a        = a + 16'h1111;
        b        = ~b;
        cin      = ~cin;
      end
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    check("latency_edges", 32'(edges), 32'(NWORDS + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(NWORDS));
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    s_snap = sum;
    c_snap = cout;
    o_snap = ovf;
    for (int i = 0; i < int'(v.hold); i++) begin
      @(posedge clk); #1;
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_sum",      32'(sum),       32'(s_snap));
      check("hold_cout",     32'(cout),      32'(c_snap));
      check("hold_ovf",      32'(ovf),       32'(o_snap));
      check("hold_in_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_cout",      32'(cout),      32'd0);
  endtask

  initial begin
    //              a         b         cin   sum       cout  ovf   dist  early hold
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{16'h0005, 16'h0006, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0});
    vecs.push_back('{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Abort: accept, then reset during the second RUN cycle; no result expected.
    wait_in_ready();
    a        = 16'h0F0F;
    b        = 16'h0101;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;               // accept
    in_valid = 1'b0;
    @(posedge clk); #1;               // first nibble done, now in 2nd RUN cycle
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy_low",  32'(busy),      32'd0);
    check("abort_sum",       32'(sum),       32'd0);
    repeat (NWORDS + 2) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(out_valid), 32'd0);
    end

    run_txn('{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});

    @(posedge clk); #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_multiword_add_ctrl
